// File: rtl/iob_fifo_t2p_ctrl.sv
// Purpose: push/pop FIFO control around an external two-port RAM (pointers, level, flags, read-valid).
// Latency: a pushed word is poppable the next cycle; popped data appears with r_valid one cycle after the pop.
// Backpressure: pushes are refused while w_full and pops while r_empty; refused requests set sticky error flags.
module iob_fifo_t2p_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_full,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              r_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    output logic              ext_mem_w_en,
    output logic [ADDR_W-1:0] ext_mem_w_addr,
    output logic [DATA_W-1:0] ext_mem_w_data,
    output logic              ext_mem_r_en,
    output logic [ADDR_W-1:0] ext_mem_r_addr,
    input  logic [DATA_W-1:0] ext_mem_r_data
);

    // Level value meaning "every RAM slot occupied".
    localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Flags come from the registered level only, so a same-cycle pop never
    // frees room for a push and a same-cycle push never feeds a pop.
    assign r_empty = (level == '0);
    assign w_full  = (level == FULL_LEVEL);

    assign push_ok = w_en & ~w_full & ~rst;
    assign pop_ok  = r_en & ~r_empty & ~rst;

    // RAM port drive: addresses and write data are always the live pointers/input;
    // only the enables are qualified by acceptance.
    assign ext_mem_w_en   = push_ok;
    assign ext_mem_w_addr = w_ptr;
    assign ext_mem_w_data = w_data;
    assign ext_mem_r_en   = pop_ok;
    assign ext_mem_r_addr = r_ptr;
    assign r_data         = ext_mem_r_data;

    // Pointer, occupancy, read-valid and sticky error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            level     <= '0;
            r_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (pop_ok) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level <= level + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level <= level - 1'b1;
            end
            // RAM output register loads on the accepted pop, so data is valid the cycle after.
            r_valid <= pop_ok;
            if (w_en && w_full) begin
                overflow <= 1'b1;
            end
            if (r_en && r_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iob_fifo_t2p_ctrl.sv
module tb_iob_fifo_t2p_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_full;
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;
    logic              ext_mem_w_en;
    logic [ADDR_W-1:0] ext_mem_w_addr;
    logic [DATA_W-1:0] ext_mem_w_data;
    logic              ext_mem_r_en;
    logic [ADDR_W-1:0] ext_mem_r_addr;
    logic [DATA_W-1:0] ext_mem_r_data;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int         model_q[$];
    int         exp_q[$];
    int         wp, rp;
    bit         exp_ov, exp_un, exp_rv;

    iob_fifo_t2p_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .w_en(w_en), .w_data(w_data), .w_full(w_full),
        .r_en(r_en), .r_data(r_data), .r_valid(r_valid), .r_empty(r_empty),
        .level(level), .overflow(overflow), .underflow(underflow),
        .ext_mem_w_en(ext_mem_w_en), .ext_mem_w_addr(ext_mem_w_addr),
        .ext_mem_w_data(ext_mem_w_data), .ext_mem_r_en(ext_mem_r_en),
        .ext_mem_r_addr(ext_mem_r_addr), .ext_mem_r_data(ext_mem_r_data)
    );

    always #5 clk = ~clk;

    // Behavioural two-port RAM with registered read output
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ext_mem_w_en) mem[ext_mem_w_addr] <= ext_mem_w_data;
        if (ext_mem_r_en) ext_mem_r_data <= mem[ext_mem_r_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every r_valid must deliver the next expected popped word
    always @(negedge clk) begin
        if (!rst && r_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL r_data: got %0d with r_valid but no pop outstanding", r_data);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(r_data) != e) begin
                    miscompares++;
                    $display("FAIL r_data: got %0d expected %0d at %0t", r_data, e, $time);
                end
            end
        end
    end

    // One clock cycle of stimulus; called right after a falling edge
    task automatic cyc(input bit w, input bit r, input int d);
        bit full, empty, pacc, racc;
        w_en = w; r_en = r; w_data = d[DATA_W-1:0];
        full  = (model_q.size() == DEPTH);
        empty = (model_q.size() == 0);
        pacc  = w && !full;
        racc  = r && !empty;
        #1;
        chk("w_full", int'(w_full), int'(full));
        chk("r_empty", int'(r_empty), int'(empty));
        chk("ext_mem_w_en", int'(ext_mem_w_en), int'(pacc));
        chk("ext_mem_r_en", int'(ext_mem_r_en), int'(racc));
        chk("ext_mem_w_addr", int'(ext_mem_w_addr), wp);
        chk("ext_mem_r_addr", int'(ext_mem_r_addr), rp);
        chk("ext_mem_w_data", int'(ext_mem_w_data), d % 256);
        if (racc) begin
            exp_q.push_back(model_q.pop_front());
            rp = (rp + 1) % DEPTH;
        end
        if (pacc) begin
            model_q.push_back(d % 256);
            wp = (wp + 1) % DEPTH;
        end
        if (w && full) exp_ov = 1;
        if (r && empty) exp_un = 1;
        exp_rv = racc;
        @(negedge clk);
        chk("level", int'(level), model_q.size());
        chk("r_valid", int'(r_valid), int'(exp_rv));
        chk("overflow", int'(overflow), int'(exp_ov));
        chk("underflow", int'(underflow), int'(exp_un));
    endtask

    // One-cycle reset pulse with requests held high to show the RAM enables stay low
    task automatic do_reset();
        rst = 1; w_en = 1; r_en = 1; w_data = 8'h5a;
        #1;
        chk("rst_w_en_gate", int'(ext_mem_w_en), 0);
        chk("rst_r_en_gate", int'(ext_mem_r_en), 0);
        @(negedge clk);
        rst = 0; w_en = 0; r_en = 0;
        model_q.delete(); exp_q.delete();
        wp = 0; rp = 0; exp_ov = 0; exp_un = 0; exp_rv = 0;
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_r_empty", int'(r_empty), 1);
        chk("rst_w_full", int'(w_full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_underflow", int'(underflow), 0);
        chk("rst_r_valid", int'(r_valid), 0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; w_en = 0; r_en = 0; w_data = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Fill, overflow, drain, underflow
        for (int i = 0; i < 16; i++) cyc(1, 0, 32 + i);
        chk("fill_level", int'(level), 16);
        chk("fill_full", int'(w_full), 1);
        cyc(1, 0, 99);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("drain_empty", int'(r_empty), 1);
        cyc(0, 1, 0);
        cyc(0, 0, 0);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 0, i);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0);
        for (int i = 0; i < 16; i++) cyc(1, 0, 100 + i);
        chk("wrap_w_addr", int'(ext_mem_w_addr), 10);
        chk("wrap_full", int'(w_full), 1);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0);
        cyc(0, 0, 0);

        // Simultaneous push+pop at level 5
        for (int i = 0; i < 5; i++) cyc(1, 0, 200 + i);
        for (int i = 0; i < 8; i++) cyc(1, 1, 50 + i);
        chk("simul_level", int'(level), 5);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0);
        cyc(0, 0, 0);

        // Push+pop while empty
        do_reset();
        cyc(1, 1, 77);
        chk("empty_both_level", int'(level), 1);
        chk("empty_both_underflow", int'(underflow), 1);

        // Push+pop while full
        for (int i = 0; i < 15; i++) cyc(1, 0, 150 + i);
        cyc(1, 1, 11);
        chk("full_both_level", int'(level), 15);
        chk("full_both_overflow", int'(overflow), 1);
        cyc(0, 0, 0);

        // Reset mid-operation at level 7
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1, 0, 60 + i);
        do_reset();
        cyc(1, 0, 1);
        cyc(1, 0, 2);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                bit w, r;
                w = ($urandom_range(0, 99) < 55);
                r = ($urandom_range(0, 99) < 50);
                cyc(w, r, int'($urandom_range(0, 255)));
            end
        end
        cyc(0, 0, 0);
        chk("final_outstanding", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
